// File: rtl/md5_pkg.sv
// Shared constants for the MD5 block controller: shift/sine tables, IV and FSM encoding.
// Consumers: md5_step_rom, md5_block_ctrl (chaining variant selected by MD5_CHAIN_EN).
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [127:0] IV_STATE = {IV_D, IV_C, IV_B, IV_A};

  // floor(|sin(i+1)| * 2^32), indexed by step
  localparam logic [31:0] T_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amount depends only on the round and the step position within a group of four
  function automatic logic [4:0] s_lookup(input logic [5:0] step);
    logic [4:0] s;
    case ({step[5:4], step[1:0]})
      4'd0:  s = 5'd7;
      4'd1:  s = 5'd12;
      4'd2:  s = 5'd17;
      4'd3:  s = 5'd22;
      4'd4:  s = 5'd5;
      4'd5:  s = 5'd9;
      4'd6:  s = 5'd14;
      4'd7:  s = 5'd20;
      4'd8:  s = 5'd4;
      4'd9:  s = 5'd11;
      4'd10: s = 5'd16;
      4'd11: s = 5'd23;
      4'd12: s = 5'd6;
      4'd13: s = 5'd10;
      4'd14: s = 5'd15;
      default: s = 5'd21;
    endcase
    return s;
  endfunction

  // Message word index; 4-bit arithmetic supplies the mod 16
  function automatic logic [3:0] g_lookup(input logic [5:0] step);
    logic [3:0] i;
    logic [3:0] g;
    i = step[3:0];
    case (step[5:4])
      2'd0:    g = i;
      2'd1:    g = i * 4'd5 + 4'd1;
      2'd2:    g = i * 4'd3 + 4'd5;
      default: g = i * 4'd7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_step_rom.sv
// Combinational step lookup: step -> shift amount, sine constant, message word index.
module md5_step_rom
  import md5_pkg::*;
(
  input  logic [5:0]  i_step,
  output logic [4:0]  o_s,
  output logic [31:0] o_t,
  output logic [3:0]  o_g
);

  assign o_s = s_lookup(i_step);
  assign o_t = T_TABLE[i_step];
  assign o_g = g_lookup(i_step);

endmodule

// File: rtl/md5round.sv
// Single MD5 step datapath: next_a = b + rotl(a + F_r(b,c,d) + m + t, s).
module md5round (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_m,
  input  logic [4:0]  i_s,
  input  logic [31:0] i_t,
  input  logic [1:0]  i_r,
  output logic [31:0] o_next_a
);

  logic [31:0] w_f;
  logic [31:0] w_sum;
  logic [31:0] w_rot;
  logic [5:0]  w_rs;

  always_comb begin
    w_f = 32'd0;
    case (i_r)
      2'd0:    w_f = (i_b & i_c) | (~i_b & i_d);
      2'd1:    w_f = (i_d & i_b) | (~i_d & i_c);
      2'd2:    w_f = i_b ^ i_c ^ i_d;
      default: w_f = i_c ^ (i_b | ~i_d);
    endcase
  end

  assign w_sum    = i_a + w_f + i_m + i_t;
  assign w_rs     = 6'd32 - {1'b0, i_s};
  assign w_rot    = (w_sum << i_s) | (w_sum >> w_rs);
  assign o_next_a = i_b + w_rot;

endmodule

// File: rtl/md5_block_ctrl.sv
// Runs one 512-bit block through 64 MD5 steps and returns input state + working state.
// Build option MD5_CHAIN_EN: replaces in_state with in_first and an internal chaining register.
module md5_block_ctrl
  import md5_pkg::*;
#(
  parameter int NSTEPS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_msg,
`ifdef MD5_CHAIN_EN
  input  logic         in_first,
`else
  input  logic [127:0] in_state,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [1:0]   o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid only in DONE, with out_state held until out_ready.

  localparam logic [6:0] LP_NSTEPS = 7'(NSTEPS);

  ctrl_state_e  r_state;
  ctrl_state_e  w_next_state;
  logic [5:0]   r_step;
  logic [511:0] r_msg;
  logic [127:0] r_save;
  logic [31:0]  r_a, r_b, r_c, r_d;
  logic [127:0] r_out_state;
  logic [127:0] w_init;
  logic         w_accept;
  logic         w_last;
  logic [4:0]   w_s;
  logic [31:0]  w_t;
  logic [3:0]   w_g;
  logic [31:0]  w_m;
  logic [31:0]  w_next_a;

`ifdef MD5_CHAIN_EN
  logic [127:0] r_chain;
  assign w_init = in_first ? IV_STATE : r_chain;
`else
  assign w_init = in_state;
`endif

  md5_step_rom u_rom (
    .i_step (r_step),
    .o_s    (w_s),
    .o_t    (w_t),
    .o_g    (w_g)
  );

  assign w_m = r_msg[{w_g, 5'd0} +: 32];

  md5round u_round (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_c      (r_c),
    .i_d      (r_d),
    .i_m      (w_m),
    .i_s      (w_s),
    .i_t      (w_t),
    .i_r      (r_step[5:4]),
    .o_next_a (w_next_a)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_step == 6'd63) begin
          w_last       = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= 6'd0;
      r_msg       <= '0;
      r_save      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_out_state <= '0;
    end else if (w_accept) begin
      r_msg  <= in_msg;
      r_save <= w_init;
      r_a    <= w_init[31:0];
      r_b    <= w_init[63:32];
      r_c    <= w_init[95:64];
      r_d    <= w_init[127:96];
      r_step <= 6'd0;
    end else if (r_state == ST_RUN) begin
      r_a    <= r_d;
      r_d    <= r_c;
      r_c    <= r_b;
      r_b    <= w_next_a;
      r_step <= r_step + 6'd1;
      // Final sum uses the post-step working values so DONE already has a stable result
      if (w_last) begin
        r_out_state <= {r_save[127:96] + r_c, r_save[95:64] + r_b,
                        r_save[63:32] + w_next_a, r_save[31:0] + r_d};
      end
    end
  end

`ifdef MD5_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= IV_STATE;
    end else if (w_last) begin
      r_chain <= {r_save[127:96] + r_c, r_save[95:64] + r_b,
                  r_save[63:32] + w_next_a, r_save[31:0] + r_d};
    end
  end
`endif

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_state   = r_out_state;
  assign o_dbg_state = r_state;

  a_last_step: assert property (@(posedge clk) disable iff (!rst_n)
    w_last |-> ({1'b0, r_step} == LP_NSTEPS - 7'd1));

endmodule
